// File: rtl/pkt_addr_router.sv
// pkt_addr_router: routes address-tagged packets to four FIFOs; define PKT_ROUTER_STATS_EN for drop_cnt
module pkt_addr_router #(
    parameter int W_WIDTH = 8,
    parameter logic [W_WIDTH-1:0] BCAST_ADDR = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W_WIDTH-1:0]   in_data,
    output logic                 in_ready,
    input  logic [4*W_WIDTH-1:0] cfg_addr,
    input  logic [3:0]           fifo_full,
    output logic [3:0]           fifo_wr_en,
    output logic [W_WIDTH-1:0]   fifo_data
`ifdef PKT_ROUTER_STATS_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD} state_t;
    state_t state, next_state;
    logic [3:0] mask, match, res_mask, cur_mask;
    logic [W_WIDTH-1:0] cnt;
    logic xfer;
    for (genvar i = 0; i < 4; i++) begin : g_match
        assign match[i] = cfg_addr[i*W_WIDTH +: W_WIDTH] == in_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (xfer && state == IDLE)
                mask <= res_mask;
            if (xfer && state == LEN)
                cnt <= in_data;
            else if (xfer && state == PAYLOAD)
                cnt <= cnt - W_WIDTH'(1);
        end
    end
    always_comb begin
        next_state = !xfer ? state :
                     state == IDLE ? LEN :
                     state == LEN ? (in_data == '0 ? IDLE : PAYLOAD) :
                     cnt == W_WIDTH'(1) ? IDLE : PAYLOAD;
    end
    // match & ~(match-1) keeps only the lowest matching port
    always_comb begin
        res_mask   = in_data == BCAST_ADDR ? 4'hF : match & ~(match - 4'd1);
        cur_mask   = state == IDLE ? res_mask : mask;
        in_ready   = rst_n && (cur_mask & fifo_full) == 4'b0;
        xfer       = in_valid && in_ready;
        fifo_wr_en = cur_mask & {4{xfer}};
        fifo_data  = in_data;
    end
`ifdef PKT_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (xfer && state == IDLE && res_mask == 4'b0 && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pkt_addr_router.sv
// tb_pkt_addr_router: directed scenarios plus randomized packet stream against a queue-based model
module tb_pkt_addr_router;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [31:0] cfg_addr = '0;
    logic [3:0]  fifo_full = '0;
    logic [3:0]  fifo_wr_en;
    logic [7:0]  fifo_data;
`ifdef PKT_ROUTER_STATS_EN
    logic [15:0] drop_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int exp_drops = 0;
    logic [7:0] exp_m [4][2048];
    logic [7:0] act_m [4][2048];
    int exp_n [4];
    int act_n [4];
    logic [7:0] strm [2048];

    pkt_addr_router dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_addr(cfg_addr), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data)
`ifdef PKT_ROUTER_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] route(input logic [7:0] a, input logic [31:0] cfg);
        if (a == 8'hFF) return 4'hF;
        for (int i = 0; i < 4; i++)
            if (cfg[i*8 +: 8] == a) return 4'(1 << i);
        return 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic v, input logic [7:0] d, input logic [3:0] full);
        in_valid = v;
        in_data = d;
        fifo_full = full;
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_drops = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set(1'b1, 8'hFF, 4'h0);
        n_chk++;
        if (in_ready !== 1'b0 || fifo_wr_en !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold: in_ready=%b wr_en=%b, required 0 0000", in_ready, fifo_wr_en);
        end
        tick();
        tick();
        set(1'b1, 8'h20, 4'h0);
        n_chk++;
        if (in_ready !== 1'b0 || fifo_wr_en !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold2: in_ready=%b wr_en=%b, required 0 0000", in_ready, fifo_wr_en);
        end
        rst_n = 1'b1;
        exp_drops = 0;
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || fifo_wr_en !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: in_ready=%b wr_en=%b, required 1 0000", in_ready, fifo_wr_en);
        end
`ifdef PKT_ROUTER_STATS_EN
        n_chk++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_unicast();
        logic [7:0] b [7] = '{8'h20, 8'h02, 8'hAA, 8'hBB, 8'h20, 8'h01, 8'h5A};
        cfg_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 6) cfg_addr[15:8] = 8'h99;
            set(1'b1, b[k], 4'h0);
            n_chk++;
            if (in_ready !== 1'b1 || fifo_wr_en !== 4'b0010 || fifo_data !== b[k]) begin
                n_fail++;
                $display("FAIL unicast[%0d]: ready=%b wr_en=%b data=%h, required 1 0010 %h",
                         k, in_ready, fifo_wr_en, fifo_data, b[k]);
            end
            tick();
        end
        set(1'b1, 8'h20, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL unicast_newcfg: wr_en=%b, required 0000", fifo_wr_en);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_drop();
        logic [7:0] b [5] = '{8'h55, 8'h03, 8'h01, 8'h02, 8'h03};
        cfg_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set(1'b1, b[k], 4'hF);
            n_chk++;
            if (in_ready !== 1'b1 || fifo_wr_en !== 4'b0000) begin
                n_fail++;
                $display("FAIL drop[%0d]: ready=%b wr_en=%b, required 1 0000", k, in_ready, fifo_wr_en);
            end
            tick();
        end
`ifdef PKT_ROUTER_STATS_EN
        n_chk++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
        end
`endif
        set(1'b1, 8'h10, 4'b0001);
        n_chk++;
        if (in_ready !== 1'b0 || fifo_wr_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_full_stall: ready=%b wr_en=%b, required 0 0000", in_ready, fifo_wr_en);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_broadcast_stall();
        cfg_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        do_reset();
        set(1'b1, 8'hFF, 4'h0);
        n_chk++;
        if (in_ready !== 1'b1 || fifo_wr_en !== 4'hF) begin
            n_fail++;
            $display("FAIL bcast_addr: ready=%b wr_en=%b, required 1 1111", in_ready, fifo_wr_en);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            set(1'b1, 8'h01, 4'b0100);
            n_chk++;
            if (in_ready !== 1'b0 || fifo_wr_en !== 4'h0) begin
                n_fail++;
                $display("FAIL bcast_stall[%0d]: ready=%b wr_en=%b, required 0 0000", k, in_ready, fifo_wr_en);
            end
            tick();
        end
        set(1'b1, 8'h01, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'hF || fifo_data !== 8'h01) begin
            n_fail++;
            $display("FAIL bcast_len: wr_en=%b data=%h, required 1111 01", fifo_wr_en, fifo_data);
        end
        tick();
        set(1'b1, 8'h7E, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'hF || fifo_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL bcast_pay: wr_en=%b data=%h, required 1111 7e", fifo_wr_en, fifo_data);
        end
        tick();
        set(1'b1, 8'h30, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'b0100) begin
            n_fail++;
            $display("FAIL bcast_after: wr_en=%b, required 0100", fifo_wr_en);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [5] = '{8'h10, 8'h00, 8'h30, 8'h01, 8'hC3};
        logic [3:0] m [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
        cfg_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set(1'b1, b[k], 4'h0);
            n_chk++;
            if (in_ready !== 1'b1 || fifo_wr_en !== m[k] || fifo_data !== b[k]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: ready=%b wr_en=%b data=%h, required 1 %b %h",
                         k, in_ready, fifo_wr_en, fifo_data, m[k], b[k]);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_dup_cfg_reset();
        logic [7:0] b [3] = '{8'h10, 8'h02, 8'hAA};
        cfg_addr = {8'h10, 8'h30, 8'h20, 8'h10};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set(1'b1, b[k], 4'h0);
            n_chk++;
            if (fifo_wr_en !== 4'b0001) begin
                n_fail++;
                $display("FAIL dup_cfg[%0d]: wr_en=%b, required 0001", k, fifo_wr_en);
            end
            tick();
        end
        rst_n = 1'b0;
        set(1'b1, 8'hBB, 4'h0);
        n_chk++;
        if (in_ready !== 1'b0 || fifo_wr_en !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b wr_en=%b, required 0 0000", in_ready, fifo_wr_en);
        end
        tick();
        rst_n = 1'b1;
        set(1'b1, 8'h20, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_addr: wr_en=%b, required 0010", fifo_wr_en);
        end
        tick();
        set(1'b1, 8'h00, 4'h0);
        n_chk++;
        if (fifo_wr_en !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_len: wr_en=%b, required 0010", fifo_wr_en);
        end
        tick();
        in_valid = 1'b0;
`ifdef PKT_ROUTER_STATS_EN
        n_chk++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_not_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int n = 0;
        int idx = 0;
        int cyc = 0;
        int bad;
        logic [3:0] pm;
        logic [7:0] dest, len;
        for (int i = 0; i < 4; i++) begin
            cfg_addr[i*8 +: 8] = 8'($urandom_range(0, 6));
            exp_n[i] = 0;
            act_n[i] = 0;
        end
        do_reset();
        for (int p = 0; p < 40; p++) begin
            dest = $urandom_range(0, 7) == 7 ? 8'hFF : 8'($urandom_range(0, 6));
            len = 8'($urandom_range(0, 4));
            pm = route(dest, cfg_addr);
            if (pm == 4'h0) exp_drops++;
            for (int j = 0; j < int'(len) + 2; j++) begin
                strm[n] = j == 0 ? dest : j == 1 ? len : 8'($urandom);
                for (int q = 0; q < 4; q++)
                    if (pm[q]) begin
                        exp_m[q][exp_n[q]] = strm[n];
                        exp_n[q]++;
                    end
                n++;
            end
        end
        while (idx < n && cyc < 20000) begin
            if ($urandom_range(0, 3) != 0) set(1'b1, strm[idx], 4'($urandom) & 4'($urandom));
            else set(1'b0, 8'($urandom), 4'($urandom) & 4'($urandom));
            n_chk++;
            if ((fifo_wr_en & fifo_full) !== 4'h0) begin
                n_fail++;
                $display("FAIL rnd_wr_full: wr_en=%b full=%b, required no overlap", fifo_wr_en, fifo_full);
            end
            n_chk++;
            if (!(in_valid && in_ready) && fifo_wr_en !== 4'h0) begin
                n_fail++;
                $display("FAIL rnd_wr_no_xfer: wr_en=%b, required 0000", fifo_wr_en);
            end
            for (int q = 0; q < 4; q++)
                if (fifo_wr_en[q] === 1'b1 && act_n[q] < 2048) begin
                    act_m[q][act_n[q]] = fifo_data;
                    act_n[q]++;
                end
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (idx != n) begin
            n_fail++;
            $display("FAIL rnd_timeout: consumed %0d bytes, required %0d", idx, n);
        end
        for (int q = 0; q < 4; q++) begin
            bad = act_n[q] != exp_n[q] ? 0 : -1;
            for (int j = 0; j < exp_n[q] && bad < 0; j++)
                if (act_m[q][j] !== exp_m[q][j]) bad = j;
            n_chk++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL rnd_port%0d: got %0d bytes (first diff at %0d), required %0d bytes",
                         q, act_n[q], bad, exp_n[q]);
            end
        end
`ifdef PKT_ROUTER_STATS_EN
        n_chk++;
        if (drop_cnt !== 16'(exp_drops)) begin
            n_fail++;
            $display("FAIL rnd_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops);
        end
`endif
    endtask

    initial begin
        tick();
        test_reset();
        test_unicast();
        test_drop();
        test_broadcast_stall();
        test_back_to_back();
        test_dup_cfg_reset();
        for (int r = 0; r < 5; r++) test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_addr_router.md
PKT_ADDR_ROUTER -- requirements
Module: pkt_addr_router

Interface
REQ-001 SHALL have parameter W_WIDTH, default 8, giving the byte width of the stream and the FIFO data.
REQ-002 SHALL have parameter BCAST_ADDR, default 8'hFF, giving the broadcast destination address.
REQ-003 SHALL have port clk, input, 1: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: the upstream byte is valid.
REQ-006 SHALL have port in_data, input, W_WIDTH: the upstream packet byte.
REQ-007 SHALL have port in_ready, output, 1: the router accepts in_data this cycle.
REQ-008 SHALL have port cfg_addr, input, 4*W_WIDTH: the port i address in slice [i*W_WIDTH +: W_WIDTH].
REQ-009 SHALL have port fifo_full, input, 4: the full flags of the four downstream port FIFOs.
REQ-010 SHALL have port fifo_wr_en, output, 4: the write enables of the four downstream port FIFOs.
REQ-011 SHALL have port fifo_data, output, W_WIDTH: the write data shared by all four FIFOs.

Function
REQ-012 SHALL treat a packet as: byte0 = destination address; byte1 = payload length L (0..2^W_WIDTH-1); then L payload bytes.
REQ-013 SHALL consider a byte transferred only on a cycle where in_valid and in_ready are both high; there is no other transfer.
REQ-014 SHALL use an FSM with states IDLE (expect address), LEN (expect length) and PAYLOAD (L bytes outstanding).
REQ-015 SHALL, on an address byte transferred in IDLE, resolve the target mask as follows:
- address == BCAST_ADDR gives 4'b1111;
- otherwise, the lowest index i with cfg_addr[i] == address gives a one-hot mask;
- no match gives 4'b0000, and the packet is dropped.
REQ-016 SHALL register the target mask at the address transfer and hold it unchanged until the packet ends; later cfg_addr changes do not affect a packet in flight.
REQ-017 SHALL drive in_ready as follows:
- in IDLE, high when no selected FIFO (from the combinational resolve of in_data) is full;
- in LEN and PAYLOAD, high when no FIFO in the registered mask is full;
- for a dropped packet (mask 0), always high.
REQ-018 SHALL drive fifo_wr_en = mask & {4{in_valid & in_ready}} combinationally, with fifo_data = in_data, giving zero latency.
REQ-019 SHALL forward all bytes of a routed packet, including address and length, so the downstream FIFO holds complete packets.
REQ-020 SHALL make these transitions:
- IDLE to LEN on the address transfer;
- LEN to IDLE when L == 0, otherwise LEN to PAYLOAD, loading a W_WIDTH-bit down-counter with L;
- PAYLOAD: decrement on each transfer, and return to IDLE on the transfer that takes the counter to 0.
REQ-021 SHALL make a broadcast write all four FIFOs in the same cycle, stalling while any of them is full; no partial broadcast writes occur.
REQ-022 SHALL allow in_valid to drop mid-packet; the FSM waits in its current state with no timeout.
REQ-023 SHALL allow back-to-back packets, accepting the next address byte on the cycle after the final byte of the previous packet.

Reset
REQ-024 SHALL, when rst_n is low at a rising clk edge, set the FSM to IDLE, the mask to 0 and the counter to 0, and clear any statistics counters.
REQ-025 SHALL, during reset, hold in_ready = 0 and fifo_wr_en = 4'b0000 regardless of the other inputs.
REQ-026 SHALL abandon a partially transferred packet on reset mid-operation, and SHALL NOT count it as dropped.

Configuration
REQ-027 SHALL, with macro PKT_ROUTER_STATS_EN defined, add output drop_cnt (16 bits): it increments on each address transfer that resolves to mask 0, saturates at 16'hFFFF and resets to 0.
REQ-028 SHALL, without PKT_ROUTER_STATS_EN, omit the drop_cnt port and logic; routing behaviour is identical in both builds.

Verification
REQ-029 SHALL cover unicast: cfg_addr = {8'h40,8'h30,8'h20,8'h10}; send 8'h20,8'h02,8'hAA,8'hBB -> fifo_wr_en = 4'b0010 on 4 consecutive cycles, data 20,02,AA,BB.
REQ-030 SHALL cover drop: send 8'h55,8'h03,x,y,z with no match -> in_ready high for 5 cycles, fifo_wr_en = 0 throughout, and drop_cnt = 1 when PKT_ROUTER_STATS_EN is defined.
REQ-031 SHALL cover broadcast with stall: send 8'hFF,8'h01,8'h7E with fifo_full[2] = 1 for 3 cycles at LEN -> in_ready low for 3 cycles, then 4'b1111 writes resume.
REQ-032 SHALL cover zero length: send 8'h10,8'h00 then 8'h30,8'h01,8'hC3 back-to-back -> 4'b0001 x2, then 4'b0100 x3, with no idle cycle between packets.
REQ-033 SHALL cover duplicate config and reset mid-packet:
- cfg_addr[0] = cfg_addr[3] = 8'h10 -> packet 8'h10 goes to port 0 only;
- rst_n low during PAYLOAD -> next byte is parsed as an address.
